pulse_decoder: RTL and testbench

Receive-side stage for the lab's single-wire pulse link: consumes the 1-bit serial line driven by the pulse-generator FSM, measures each high pulse with a cycle counter, classifies it as 0 (short) or 1 (long), and assembles MSB-first frames into bytes. Completed bytes are held in a one-entry output register with a valid/ready handshake. Malformed pulses, gap timeouts and overruns are flagged.

---
 rtl/pulse_decoder.sv | 126 ++++++++++++
 tb/tb_pulse_decoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pulse_decoder.sv
// pulse_decoder: pulse-width decoder assembling MSB-first bytes with a valid/ready output register; optional parity check via PULSE_DEC_PARITY_EN
module pulse_decoder #(
  parameter int unsigned T_UNIT = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       err,
  output logic       ovf
);
`ifdef PULSE_DEC_PARITY_EN
  localparam int unsigned FRAME = 9;
`else
  localparam int unsigned FRAME = 8;
`endif
  localparam logic [31:0] LIM_BIT  = 32'(2 * T_UNIT);
  localparam logic [31:0] LIM_HIGH = 32'(5 * T_UNIT);
  localparam logic [31:0] LIM_GAP  = 32'(4 * T_UNIT);
  typedef enum logic [1:0] {IDLE, HIGH, LOW, ERR} state_t;
  state_t           state_q;
  logic             sync_q, s_q;
  logic [31:0]      count_q, count_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic [3:0]       bits_q, bits_d;
  logic [7:0]       data_q, byte_d;
  logic             valid_q, err_q, ovf_q;
  logic             done_d, byte_ok_d, accept_d;
  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign err        = err_q;
  assign ovf        = ovf_q;
  // two-flop synchronizer for the asynchronous line
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      sync_q <= line_in;
      s_q    <= sync_q;
    end
  end
  // saturating increment, pulse classification and frame completion
  always_comb begin
    count_d  = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
    shift_d  = {shift_q[FRAME-2:0], count_q >= LIM_BIT};
    bits_d   = bits_q + 4'd1;
    done_d   = bits_d == 4'(FRAME);
    accept_d = !valid_q || data_ready;
`ifdef PULSE_DEC_PARITY_EN
    byte_d    = shift_d[8:1];
    byte_ok_d = ~^shift_d;
`else
    byte_d    = shift_d;
    byte_ok_d = 1'b1;
`endif
  end
  // receive FSM with registered byte, handshake and error/overflow pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      shift_q <= '0;
      bits_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      if (valid_q && data_ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: if (s_q) begin
          state_q <= HIGH;
          count_q <= 32'd1;
          bits_q  <= '0;
          shift_q <= '0;
        end
        HIGH: if (s_q) begin
          count_q <= count_d;
          if (count_d == LIM_HIGH) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            count_q <= '0;
          end
        end else begin
          shift_q <= shift_d;
          bits_q  <= bits_d;
          count_q <= 32'd1;
          state_q <= LOW;
          if (done_d) begin
            state_q <= IDLE;
            count_q <= '0;
            if (!byte_ok_d) err_q <= 1'b1;
            else if (accept_d) begin
              data_q  <= byte_d;
              valid_q <= 1'b1;
            end else ovf_q <= 1'b1;
          end
        end
        LOW: if (s_q) begin
          state_q <= HIGH;
          count_q <= 32'd1;
        end else begin
          count_q <= count_d;
          if (count_d == LIM_GAP) begin
            state_q <= ERR;
            err_q   <= 1'b1;
            count_q <= '0;
            bits_q  <= '0;
            shift_q <= '0;
          end
        end
        ERR: if (s_q) count_q <= '0;
        else if (count_d == LIM_GAP) begin
          state_q <= IDLE;
          count_q <= '0;
        end else count_q <= count_d;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_decoder.sv
// tb_pulse_decoder: directed-vector bench for pulse_decoder at T_UNIT=4
module tb_pulse_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       line_in = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, err, ovf;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_cnt = 0;
  pulse_decoder #(.T_UNIT(4)) dut (
    .clk(clk), .reset(reset), .line_in(line_in), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .err(err), .ovf(ovf)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (reset && err) err_cnt++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse(input int hi, input int lo);
    line_in = 1'b1;
    cyc(hi);
    line_in = 1'b0;
    cyc(lo);
  endtask
  task automatic send_byte(input logic [7:0] b, input int hi1, input int hi0, input int gap, input int last_lo, input logic bad);
    logic [8:0] v;
    int n;
`ifdef PULSE_DEC_PARITY_EN
    v = {b, (^b) ^ bad};
    n = 9;
`else
    v = {bad, b};
    n = 8;
`endif
    for (int i = n - 1; i >= 0; i--) pulse(v[i] ? hi1 : hi0, i == 0 ? last_lo : gap);
  endtask
  task automatic consume(input string tag);
    data_ready = 1'b1;
    cyc(1);
    data_ready = 1'b0;
    check(tag, 32'(data_valid), 32'd0);
  endtask
  initial begin
    cyc(3);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset = 1'b1;
    cyc(2);
    send_byte(8'hA5, 12, 4, 4, 2, 1'b0);
    check("a5_not_early", 32'(data_valid), 32'd0);
    cyc(1);
    check("a5_valid", 32'(data_valid), 32'd1);
    check("a5_data", 32'(data_out), 32'hA5);
    check("a5_no_err", 32'(err_cnt), 32'd0);
    consume("a5_consume");
    send_byte(8'h3C, 12, 4, 4, 3, 1'b0);
    check("3c_valid", 32'(data_valid), 32'd1);
    check("3c_data", 32'(data_out), 32'h3C);
    send_byte(8'h81, 12, 4, 4, 3, 1'b0);
    check("ovf_pulse", 32'(ovf), 32'd1);
    check("ovf_data_kept", 32'(data_out), 32'h3C);
    check("ovf_valid_kept", 32'(data_valid), 32'd1);
    cyc(1);
    check("ovf_one_cycle", 32'(ovf), 32'd0);
    consume("ovf_consume");
    line_in = 1'b1;
    cyc(20);
    line_in = 1'b0;
    cyc(2);
    check("long_err", 32'(err), 32'd1);
    cyc(1);
    check("long_err_end", 32'(err), 32'd0);
    check("long_no_byte", 32'(data_valid), 32'd0);
    cyc(13);
    send_byte(8'h55, 12, 4, 4, 3, 1'b0);
    check("55_data", 32'(data_out), 32'h55);
    check("55_valid", 32'(data_valid), 32'd1);
    consume("55_consume");
    pulse(12, 4);
    pulse(4, 4);
    line_in = 1'b1;
    cyc(12);
    line_in = 1'b0;
    cyc(17);
    check("gap_err_early", 32'(err), 32'd0);
    cyc(1);
    check("gap_err", 32'(err), 32'd1);
    check("gap_no_byte", 32'(data_valid), 32'd0);
    cyc(16);
    send_byte(8'hC3, 12, 4, 4, 3, 1'b0);
    check("c3_data", 32'(data_out), 32'hC3);
    check("err_total", 32'(err_cnt), 32'd2);
    for (int i = 0; i < 4; i++) pulse(12, 4);
    reset = 1'b0;
    #2;
    check("arst_data", 32'(data_out), 32'h0);
    check("arst_valid", 32'(data_valid), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(2);
    send_byte(8'hFF, 12, 4, 4, 3, 1'b0);
    check("ff_data", 32'(data_out), 32'hFF);
    check("ff_valid", 32'(data_valid), 32'd1);
    consume("ff_consume");
    send_byte(8'h96, 8, 7, 15, 3, 1'b0);
    check("edge_lo_data", 32'(data_out), 32'h96);
    consume("edge_lo_consume");
    send_byte(8'h69, 19, 1, 1, 3, 1'b0);
    check("edge_hi_data", 32'(data_out), 32'h69);
    check("edge_no_err", 32'(err_cnt), 32'd2);
    consume("edge_hi_consume");
`ifdef PULSE_DEC_PARITY_EN
    send_byte(8'h03, 12, 4, 4, 3, 1'b0);
    check("par_ok_data", 32'(data_out), 32'h03);
    check("par_ok_valid", 32'(data_valid), 32'd1);
    consume("par_ok_consume");
    send_byte(8'h03, 12, 4, 4, 3, 1'b1);
    check("par_bad_err", 32'(err), 32'd1);
    check("par_bad_valid", 32'(data_valid), 32'd0);
    check("par_bad_ovf", 32'(ovf), 32'd0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
